// File: rtl/accel_pair_scheduler.sv
// accel_pair_scheduler: walks every ordered body pair (i, j != i) through a fixed-latency
// acceleration unit, chaining the running acceleration and emitting one result per body.
module accel_pair_scheduler #(
  parameter int N_BODIES = 8,
  parameter int ACC_LAT = 15,
  localparam int IW = (N_BODIES > 1) ? $clog2(N_BODIES) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ld_valid,
  input  logic [IW-1:0] i_ld_idx,
  input  logic [31:0]   i_ld_x,
  input  logic [31:0]   i_ld_y,
  input  logic [31:0]   i_ld_m,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [31:0]   o_b1_x,
  output logic [31:0]   o_b1_y,
  output logic [31:0]   o_b2_x,
  output logic [31:0]   o_b2_y,
  output logic [31:0]   o_m_b2,
  output logic [31:0]   o_a_b1_x,
  output logic [31:0]   o_a_b1_y,
  output logic          o_issue,
  input  logic [31:0]   i_a_b1_x,
  input  logic [31:0]   i_a_b1_y,
  output logic          o_res_valid,
  output logic [IW-1:0] o_res_idx,
  output logic [31:0]   o_res_ax,
  output logic [31:0]   o_res_ay
);
  localparam int CW = (ACC_LAT > 1) ? $clog2(ACC_LAT + 1) : 1;
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, EMIT = 3'd3, DONE = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic [31:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   st_x_q [N_BODIES];
  logic [31:0]   st_y_q [N_BODIES];
  logic [31:0]   st_m_q [N_BODIES];
  logic [IW:0]   nj_inc, nj;
  // next partner index skips the body itself; one extra bit flags running off the end
  assign nj_inc = {1'b0, j_q} + (IW+1)'(1);
  assign nj = (nj_inc == {1'b0, i_q}) ? nj_inc + (IW+1)'(1) : nj_inc;
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = (N_BODIES == 1) ? EMIT : ISSUE;
        i_d = '0;
        j_d = (N_BODIES > 1) ? IW'(1) : '0;
        acc_x_d = '0;
        acc_y_d = '0;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = CW'(1);
      end
      WAIT: if (cnt_q == CW'(ACC_LAT)) begin
        acc_x_d = i_a_b1_x;
        acc_y_d = i_a_b1_y;
        j_d = nj[IW-1:0];
        state_d = (nj >= (IW+1)'(N_BODIES)) ? EMIT : ISSUE;
      end else cnt_d = cnt_q + CW'(1);
      EMIT: if (i_q == IW'(N_BODIES - 1)) state_d = DONE;
      else begin
        i_d = i_q + IW'(1);
        j_d = '0;
        acc_x_d = '0;
        acc_y_d = '0;
        state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      cnt_q <= cnt_d;
    end
  end
  // store survives reset; a load coinciding with start is dropped
  always_ff @(posedge i_clk) begin
    if (i_ld_valid && !i_start && state_q == IDLE) begin
      st_x_q[i_ld_idx] <= i_ld_x;
      st_y_q[i_ld_idx] <= i_ld_y;
      st_m_q[i_ld_idx] <= i_ld_m;
    end
  end
  assign o_busy = state_q != IDLE;
  assign o_done = state_q == DONE;
  assign o_issue = state_q == ISSUE;
  assign o_res_valid = state_q == EMIT;
  assign o_b1_x = o_issue ? st_x_q[i_q] : '0;
  assign o_b1_y = o_issue ? st_y_q[i_q] : '0;
  assign o_b2_x = o_issue ? st_x_q[j_q] : '0;
  assign o_b2_y = o_issue ? st_y_q[j_q] : '0;
  assign o_m_b2 = o_issue ? st_m_q[j_q] : '0;
  assign o_a_b1_x = o_issue ? acc_x_q : '0;
  assign o_a_b1_y = o_issue ? acc_y_q : '0;
  assign o_res_idx = o_res_valid ? i_q : '0;
  assign o_res_ax = o_res_valid ? acc_x_q : '0;
  assign o_res_ay = o_res_valid ? acc_y_q : '0;
endmodule

// File: tb/tb_accel_pair_scheduler.sv
// tb_accel_pair_scheduler: directed checks of 2-, 8- and 1-body builds against +1 accelerator stubs.
module tb_accel_pair_scheduler;
  localparam int LAT = 15;
  logic clk = 0, rst = 1;
  logic [31:0] ld_x = 0, ld_y = 0, ld_m = 0;
  logic ld_v2 = 0, ld_v8 = 0, start2 = 0, start8 = 0, start1 = 0;
  logic ld_i2 = 0;
  logic [2:0] ld_i8 = 0;
  int cyc = 0, n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic d2_busy, d2_done, d2_issue, d2_rv, d2_ridx;
  logic [31:0] d2_b1x, d2_b1y, d2_b2x, d2_b2y, d2_m, d2_ax, d2_ay, d2_iax, d2_iay, d2_rax, d2_ray;
  logic d8_busy, d8_done, d8_issue, d8_rv;
  logic [2:0] d8_ridx;
  logic [31:0] d8_b1x, d8_b1y, d8_b2x, d8_b2y, d8_m, d8_ax, d8_ay, d8_iax, d8_iay, d8_rax, d8_ray;
  logic d1_busy, d1_done, d1_issue, d1_rv, d1_ridx;
  logic [31:0] d1_b1x, d1_b1y, d1_b2x, d1_b2y, d1_m, d1_ax, d1_ay, d1_rax, d1_ray;
  accel_pair_scheduler #(.N_BODIES(2), .ACC_LAT(LAT)) u2 (
    .i_clk(clk), .i_rst(rst), .i_ld_valid(ld_v2), .i_ld_idx(ld_i2), .i_ld_x(ld_x), .i_ld_y(ld_y),
    .i_ld_m(ld_m), .i_start(start2), .o_busy(d2_busy), .o_done(d2_done), .o_b1_x(d2_b1x),
    .o_b1_y(d2_b1y), .o_b2_x(d2_b2x), .o_b2_y(d2_b2y), .o_m_b2(d2_m), .o_a_b1_x(d2_ax),
    .o_a_b1_y(d2_ay), .o_issue(d2_issue), .i_a_b1_x(d2_iax), .i_a_b1_y(d2_iay),
    .o_res_valid(d2_rv), .o_res_idx(d2_ridx), .o_res_ax(d2_rax), .o_res_ay(d2_ray));
  accel_pair_scheduler #(.N_BODIES(8), .ACC_LAT(LAT)) u8 (
    .i_clk(clk), .i_rst(rst), .i_ld_valid(ld_v8), .i_ld_idx(ld_i8), .i_ld_x(ld_x), .i_ld_y(ld_y),
    .i_ld_m(ld_m), .i_start(start8), .o_busy(d8_busy), .o_done(d8_done), .o_b1_x(d8_b1x),
    .o_b1_y(d8_b1y), .o_b2_x(d8_b2x), .o_b2_y(d8_b2y), .o_m_b2(d8_m), .o_a_b1_x(d8_ax),
    .o_a_b1_y(d8_ay), .o_issue(d8_issue), .i_a_b1_x(d8_iax), .i_a_b1_y(d8_iay),
    .o_res_valid(d8_rv), .o_res_idx(d8_ridx), .o_res_ax(d8_rax), .o_res_ay(d8_ray));
  accel_pair_scheduler #(.N_BODIES(1), .ACC_LAT(LAT)) u1 (
    .i_clk(clk), .i_rst(rst), .i_ld_valid(1'b0), .i_ld_idx(1'b0), .i_ld_x(ld_x), .i_ld_y(ld_y),
    .i_ld_m(ld_m), .i_start(start1), .o_busy(d1_busy), .o_done(d1_done), .o_b1_x(d1_b1x),
    .o_b1_y(d1_b1y), .o_b2_x(d1_b2x), .o_b2_y(d1_b2y), .o_m_b2(d1_m), .o_a_b1_x(d1_ax),
    .o_a_b1_y(d1_ay), .o_issue(d1_issue), .i_a_b1_x(32'h0), .i_a_b1_y(32'h0),
    .o_res_valid(d1_rv), .o_res_idx(d1_ridx), .o_res_ax(d1_rax), .o_res_ay(d1_ray));
  logic [31:0] p2x [LAT], p2y [LAT], p8x [LAT], p8y [LAT];
  always @(posedge clk) begin
    p2x[0] <= d2_issue ? d2_ax + 32'h1 : 32'h0;
    p2y[0] <= d2_issue ? d2_ay + 32'h1 : 32'h0;
    p8x[0] <= d8_issue ? d8_ax + 32'h1 : 32'h0;
    p8y[0] <= d8_issue ? d8_ay + 32'h1 : 32'h0;
    for (int k = 1; k < LAT; k++) begin
      p2x[k] <= p2x[k-1];
      p2y[k] <= p2y[k-1];
      p8x[k] <= p8x[k-1];
      p8y[k] <= p8y[k-1];
    end
  end
  assign d2_iax = p2x[LAT-1];
  assign d2_iay = p2y[LAT-1];
  assign d8_iax = p8x[LAT-1];
  assign d8_iay = p8y[LAT-1];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask
  function automatic logic [31:0] x8(input int k); return 32'h4000_0000 + 32'(k); endfunction
  function automatic logic [31:0] y8(input int k); return 32'h4100_0000 + 32'(k); endfunction
  function automatic logic [31:0] m8(input int k); return 32'h3F80_0000 + 32'(k); endfunction
  logic [31:0] x2 [2] = '{32'h40E0_0000, 32'h3F80_0000};
  logic [31:0] m2 [2] = '{32'h3F80_0000, 32'h3F80_0000};
  int mi2 = 0, nres2 = 0, ndone2 = 0, tdone2 = 0, iss2 = 0;
  int mi8 = 0, mj8 = 1, pc8 = 0, nres8 = 0, ndone8 = 0, tdone8 = 0, iss8 = 0, last8 = -1, gap8 = 1000;
  int iss1 = 0;
  always @(negedge clk) begin
    if (d2_issue) begin
      iss2++;
      check("n2 b1x", d2_b1x, x2[mi2]);
      check("n2 b1y", d2_b1y, x2[mi2]);
      check("n2 b2x", d2_b2x, x2[1-mi2]);
      check("n2 b2y", d2_b2y, x2[1-mi2]);
      check("n2 m", d2_m, m2[1-mi2]);
      check("n2 acc_in", d2_ax, 32'h0);
    end
    if (d2_rv) begin
      check("n2 res_idx", 32'(d2_ridx), 32'(mi2));
      check("n2 res_ax", d2_rax, 32'h1);
      check("n2 res_ay", d2_ray, 32'h1);
      mi2++;
      nres2++;
    end
    if (d2_done) begin ndone2++; tdone2 = cyc; end
    if (d8_issue) begin
      iss8++;
      if (last8 >= 0 && cyc - last8 < gap8) gap8 = cyc - last8;
      last8 = cyc;
      check("n8 b1x", d8_b1x, x8(mi8));
      check("n8 b1y", d8_b1y, y8(mi8));
      check("n8 b2x", d8_b2x, x8(mj8));
      check("n8 b2y", d8_b2y, y8(mj8));
      check("n8 m", d8_m, m8(mj8));
      check("n8 acc_in_x", d8_ax, 32'(pc8));
      check("n8 acc_in_y", d8_ay, 32'(pc8));
      pc8++;
      mj8++;
      if (mj8 == mi8) mj8++;
    end
    if (d8_rv) begin
      check("n8 res_idx", 32'(d8_ridx), 32'(mi8));
      check("n8 res_ax", d8_rax, 32'h7);
      check("n8 res_ay", d8_ray, 32'h7);
      nres8++;
      mi8++;
      mj8 = 0;
      pc8 = 0;
    end
    if (d8_done) begin ndone8++; tdone8 = cyc; end
    if (d1_issue) iss1++;
  end
  task automatic ld2(input int k, input logic [31:0] x, y, m);
    @(negedge clk);
    ld_v2 = 1; ld_i2 = k[0]; ld_x = x; ld_y = y; ld_m = m;
    @(negedge clk);
    ld_v2 = 0;
  endtask
  task automatic ld8(input int k, input logic [31:0] x, y, m);
    @(negedge clk);
    ld_v8 = 1; ld_i8 = 3'(k); ld_x = x; ld_y = y; ld_m = m;
    @(negedge clk);
    ld_v8 = 0;
  endtask
  task automatic reset8_model();
    mi8 = 0; mj8 = 1; pc8 = 0; nres8 = 0; ndone8 = 0; iss8 = 0; last8 = -1; gap8 = 1000;
  endtask
  int t0;
  initial begin
    repeat (3) @(negedge clk);
    check("rst busy", 32'(d8_busy), 0);
    check("rst done", 32'(d8_done), 0);
    check("rst issue", 32'(d8_issue), 0);
    check("rst res_valid", 32'(d8_rv), 0);
    check("rst b1x", d8_b1x, 32'h0);
    check("rst acc_in", d8_ax, 32'h0);
    check("rst res_ax", d8_rax, 32'h0);
    rst = 0;
    ld2(0, 32'h40E0_0000, 32'h40E0_0000, 32'h3F80_0000);
    ld2(1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    for (int k = 0; k < 8; k++) ld8(k, x8(k), y8(k), m8(k));
    // two-body pass with latency measurement
    @(negedge clk);
    start2 = 1; t0 = cyc;
    @(negedge clk);
    start2 = 0;
    check("n2 busy", 32'(d2_busy), 1);
    for (int k = 0; k < 200 && ndone2 == 0; k++) @(negedge clk);
    check("n2 done count", 32'(ndone2), 1);
    check("n2 pass cycles", 32'(tdone2 - t0), 35);
    check("n2 results", 32'(nres2), 2);
    check("n2 issues", 32'(iss2), 2);
    @(negedge clk);
    check("n2 idle busy", 32'(d2_busy), 0);
    // load in the same cycle as start is dropped, start still taken
    mi2 = 0; nres2 = 0; ndone2 = 0; iss2 = 0;
    @(negedge clk);
    start2 = 1; ld_v2 = 1; ld_i2 = 0; ld_x = 32'hDEAD_BEEF; ld_y = 32'hDEAD_BEEF; t0 = cyc;
    @(negedge clk);
    start2 = 0; ld_v2 = 0;
    for (int k = 0; k < 200 && ndone2 == 0; k++) @(negedge clk);
    check("n2b pass cycles", 32'(tdone2 - t0), 35);
    check("n2b results", 32'(nres2), 2);
    // eight-body pass with stray start and a load while busy
    reset8_model();
    @(negedge clk);
    start8 = 1; t0 = cyc;
    @(negedge clk);
    start8 = 0;
    repeat (100) @(negedge clk);
    start8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (20) @(negedge clk);
    ld8(1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    for (int k = 0; k < 2000 && ndone8 == 0; k++) @(negedge clk);
    repeat (30) @(negedge clk);
    check("n8 done count", 32'(ndone8), 1);
    check("n8 pass cycles", 32'(tdone8 - t0), 905);
    check("n8 issues", 32'(iss8), 56);
    check("n8 min gap", 32'(gap8), LAT + 1);
    check("n8 results", 32'(nres8), 8);
    check("n8 idle busy", 32'(d8_busy), 0);
    // abort during the wait of body 3, then a clean pass
    reset8_model();
    @(negedge clk);
    start8 = 1;
    @(negedge clk);
    start8 = 0;
    for (int k = 0; k < 2000 && nres8 < 3; k++) @(negedge clk);
    for (int k = 0; k < 50 && !d8_issue; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort busy", 32'(d8_busy), 0);
    check("abort issue", 32'(d8_issue), 0);
    repeat (40) @(negedge clk);
    check("abort no done", 32'(ndone8), 0);
    check("abort results", 32'(nres8), 3);
    reset8_model();
    @(negedge clk);
    start8 = 1; t0 = cyc;
    @(negedge clk);
    start8 = 0;
    for (int k = 0; k < 2000 && ndone8 == 0; k++) @(negedge clk);
    check("n8r pass cycles", 32'(tdone8 - t0), 905);
    check("n8r issues", 32'(iss8), 56);
    check("n8r results", 32'(nres8), 8);
    // single-body build
    @(negedge clk);
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    check("n1 res_valid", 32'(d1_rv), 1);
    check("n1 res_idx", 32'(d1_ridx), 0);
    check("n1 res_ax", d1_rax, 32'h0);
    check("n1 res_ay", d1_ray, 32'h0);
    check("n1 busy", 32'(d1_busy), 1);
    @(negedge clk);
    check("n1 done", 32'(d1_done), 1);
    check("n1 res_valid off", 32'(d1_rv), 0);
    @(negedge clk);
    check("n1 idle", 32'(d1_busy), 0);
    check("n1 issues", 32'(iss1), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/accel_pair_scheduler.md
ACCEL_PAIR_SCHEDULER -- requirements
Module: accel_pair_scheduler

Interface
REQ-001 SHALL have parameter N_BODIES, default 8, number of bodies in local store (legal range 1..64).
REQ-002 SHALL have parameter ACC_LAT, default 15, fixed accelerator latency in cycles from input presentation to o_a_b1_x/y valid.
REQ-003 SHALL use IW = clog2(N_BODIES), minimum 1, as the index width.
REQ-004 SHALL have port i_clk, in, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, in, 1, synchronous active-high reset.
REQ-006 SHALL have port i_ld_valid, in, 1, body-store write strobe.
REQ-007 SHALL have port i_ld_idx, in, IW, body index to write.
REQ-008 SHALL have ports i_ld_x, i_ld_y, i_ld_m, in, 32 each, IEEE-754 single position x/y and mass.
REQ-009 SHALL have port i_start, in, 1, one-cycle pulse that begins a full N-body pass.
REQ-010 SHALL have port o_busy, out, 1, high from the cycle after an accepted start through the o_done cycle.
REQ-011 SHALL have port o_done, out, 1, one-cycle pulse at pass end.
REQ-012 SHALL have ports o_b1_x, o_b1_y, o_b2_x, o_b2_y, o_m_b2, out, 32 each, pair operands to the accelerator.
REQ-013 SHALL have ports o_a_b1_x, o_a_b1_y, out, 32 each, running acceleration fed to the accelerator.
REQ-014 SHALL have port o_issue, out, 1, high in the cycle the operands are valid.
REQ-015 SHALL have ports i_a_b1_x, i_a_b1_y, in, 32 each, accelerator outputs.
REQ-016 SHALL have ports o_res_valid (out, 1), o_res_idx (out, IW), o_res_ax and o_res_ay (out, 32 each), the final acceleration per body.

Function
REQ-017 SHALL hold a register store of N_BODIES entries of {x, y, m}, written when i_ld_valid=1 and the FSM is in IDLE; writes in any other state are ignored.
REQ-018 SHALL implement the FSM states IDLE, ISSUE, WAIT, EMIT and DONE.
REQ-019 SHALL go from IDLE to ISSUE on i_start; set i=0 and j to the first index not equal to i; clear accumulator acc_x/acc_y to 32'h0.
REQ-020 SHALL, in ISSUE (exactly one cycle), set o_issue=1, b1=store[i].{x,y}, b2=store[j].{x,y}, o_m_b2=store[j].m and o_a_b1_x/y=acc_x/y, then go to WAIT.
REQ-021 SHALL count ACC_LAT cycles in WAIT; in the cycle exactly ACC_LAT cycles after the issue cycle, capture acc_x/y = i_a_b1_x/y.
REQ-022 SHALL, in the capture cycle, advance j to the next index not equal to i and go to ISSUE; if no such j exists, go to EMIT.
REQ-023 SHALL, in EMIT (one cycle), set o_res_valid=1, o_res_idx=i and o_res_ax/ay=acc_x/y.
REQ-024 SHALL, after EMIT, go to DONE if i=N_BODIES-1; otherwise increment i, clear acc and set j to the first index not equal to i, then go to ISSUE.
REQ-025 SHALL, in DONE (one cycle), pulse o_done=1, then return to IDLE.
REQ-026 SHALL, with N_BODIES=1, go directly IDLE -> EMIT (result 0, 0) -> DONE, with no issues.
REQ-027 SHALL drive all operand outputs to 32'h0 whenever o_issue=0.
REQ-028 SHALL ignore i_start while o_busy=1.
REQ-029 SHALL not modify the store when i_ld_valid and i_start occur in the same IDLE cycle, and SHALL still accept the start.
REQ-030 SHALL perform no floating-point arithmetic; data is passed through bit-exact.
REQ-031 SHALL take exactly N*(N-1)*(ACC_LAT+1) + N + 1 cycles from start acceptance to the o_done cycle inclusive of EMIT/DONE, for N>1.

Reset
REQ-032 SHALL, while i_rst=1, force the FSM to IDLE and set i, j, acc, the wait counter, o_busy, o_done, o_issue and o_res_valid to 0, with all data outputs 32'h0.
REQ-033 SHALL have i_rst mid-pass abort the pass with no o_done and no further o_res_valid.
REQ-034 SHALL leave store contents unaffected by reset.

Verification (stub accelerator: ACC_LAT-cycle delay, o_a = i_a + 32'h1 integer)
REQ-035 SHALL verify: N=2, load (7.0,7.0,1.0) and (1.0,1.0,1.0), start -> o_issue with b1=40E00000, b2=3F800000, m=3F800000; results idx0 ax=ay=0x1, idx1 ax=ay=0x1; o_done 2*1*16+3=35 cycles after start.
REQ-036 SHALL verify: N=8, full pass -> eight o_res_valid in idx order 0..7, each ax=ay=0x7; o_issue count 56; no two issues closer than ACC_LAT+1 cycles.
REQ-037 SHALL verify: i_start pulsed while busy -> ignored; pass length unchanged; single o_done.
REQ-038 SHALL verify: i_ld_valid during busy (idx1, x=0x12345678) -> store unchanged; the next pass issues the original b2 value for idx1.
REQ-039 SHALL verify: i_rst asserted in WAIT of body 3 -> next cycle IDLE, o_busy=0, no o_done; a new start produces the full correct pass.
REQ-040 SHALL verify: N=1 build, start -> o_res_valid idx0 with 0x0/0x0 next cycle, then o_done, zero issues.
